// File: rtl/ecg_uart_pkg.sv
// rtl/ecg_uart_pkg.sv - shared types, constants and helpers for the ECG sample UART path
// Purpose: baud divisor helper, sync byte constant and the 8N1 bit FSM state enum.
// Ports: none (package).
package ecg_uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Nearest-integer clocks per UART bit.
  function automatic int clks_per_bit(input real fclk, input real baud);
    return $rtoi(fclk / baud + 0.5);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with stream-style byte input
// Purpose: sends one byte as start(0), 8 data bits LSB first, stop(1).
//   byte_tready_o is also high during the final clock of a stop bit so the
//   next byte's start bit follows with no idle gap.
// Ports:
//   clk, rst       clock, async active-high reset
//   byte_tdata_i   byte to send
//   byte_tvalid_i  byte available
//   byte_tready_o  serializer will take byte_tdata_i on this edge
//   tx_o           serial line, idle high
module uart_tx_byte
  import ecg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 521
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_tdata_i,
  input  logic       byte_tvalid_i,
  output logic       byte_tready_o,
  output logic       tx_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        bit_end;

  assign bit_end       = (cnt_q == CNT_LAST);
  assign byte_tready_o = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign tx_o          = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          tx_q  <= 1'b1;
          if (byte_tvalid_i) begin
            shift_q <= byte_tdata_i;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q     <= '0;
            tx_q      <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            // Chain straight into the next start bit when a byte is waiting.
            if (byte_tvalid_i) begin
              shift_q <= byte_tdata_i;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axis_sample_uart_tx.sv
// rtl/axis_sample_uart_tx.sv - stream sink serializing ECG samples onto a UART line
// Purpose: captures one sample per handshake and sends it MSB byte first as
//   8N1 frames. Optional feature macro SYNC_HEADER_EN prefixes each sample
//   with sync byte 8'hA5.
// Ports:
//   clk, rst        clock, async active-high reset
//   s_axis_tdata    signed sample (inout_width bits)
//   s_axis_tvalid   sample valid
//   s_axis_tready   registered, high only while idle
//   tx              UART output, idle high
//   busy            high while a frame sequence is in progress
module axis_sample_uart_tx
  import ecg_uart_pkg::*;
#(
  parameter real FCLK        = 60e6,
  parameter real BAUD        = 115200,
  parameter int  inout_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [inout_width-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic                   tx,
  output logic                   busy
);

  localparam int CPB    = clks_per_bit(FCLK, BAUD);
  localparam int NBYTES = inout_width / 8;
`ifdef SYNC_HEADER_EN
  localparam int NFRAMES = NBYTES + 1;
`else
  localparam int NFRAMES = NBYTES;
`endif
  localparam int IW = $clog2(NFRAMES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NFRAMES - 1);

  if (CPB < 2) begin : g_cpb_chk
    $error("clocks per bit must be at least 2");
  end
  if ((inout_width % 8) != 0 || inout_width < 8) begin : g_width_chk
    $error("inout_width must be a non-zero multiple of 8");
  end

  logic [inout_width-1:0] sample_q;
  logic [IW-1:0]          byte_idx_q;
  logic                   byte_vld_q;
  logic                   s_tready_q;
  logic                   busy_q;
  logic [inout_width-1:0] sample_shl;
  logic [7:0]             byte_tdata;
  logic                   byte_tready;

  // Move the selected byte to the top; byte 0 of the sample is the MSB byte.
  always_comb begin
    sample_shl = '0;
    byte_tdata = '0;
`ifdef SYNC_HEADER_EN
    sample_shl = sample_q << {byte_idx_q - 1'b1, 3'b000};
    byte_tdata = (byte_idx_q == '0) ? SYNC_BYTE : sample_shl[inout_width-1 -: 8];
`else
    sample_shl = sample_q << {byte_idx_q, 3'b000};
    byte_tdata = sample_shl[inout_width-1 -: 8];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q   <= '0;
      byte_idx_q <= '0;
      byte_vld_q <= 1'b0;
      s_tready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (!busy_q) begin
      s_tready_q <= 1'b1;
      if (s_axis_tvalid && s_tready_q) begin
        sample_q   <= s_axis_tdata;
        byte_idx_q <= '0;
        byte_vld_q <= 1'b1;
        s_tready_q <= 1'b0;
        busy_q     <= 1'b1;
      end
    end else if (byte_tready) begin
      if (byte_vld_q) begin
        if (byte_idx_q == LAST_IDX) byte_vld_q <= 1'b0;
        else                        byte_idx_q <= byte_idx_q + 1'b1;
      end else begin
        // Serializer is ending the last stop bit with nothing queued.
        busy_q     <= 1'b0;
        s_tready_q <= 1'b1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_tx (
    .clk          (clk),
    .rst          (rst),
    .byte_tdata_i (byte_tdata),
    .byte_tvalid_i(byte_vld_q),
    .byte_tready_o(byte_tready),
    .tx_o         (tx)
  );

  assign s_axis_tready = s_tready_q;
  assign busy          = busy_q;

endmodule
